// File: rtl/inst_mem_pkg.sv
// rtl/inst_mem_pkg.sv - shared types and helpers for the loadable instruction memory
package inst_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Trap pattern bit; replicated to the word width by users of the package
  localparam logic DEFAULT_FILL_BIT = 1'b1;

  function automatic int beats_per_word(input int dw, input int lw);
    return dw / lw;
  endfunction

endpackage

// File: rtl/inst_mem_loadable_if.sv
// rtl/inst_mem_loadable_if.sv - loader and fetch bus of the loadable instruction memory
interface inst_mem_loadable_if #(
  parameter int IW = 9,
  parameter int DW = 32,
  parameter int LW = 8
);

  logic          load_start;
  logic          load_valid;
  logic [LW-1:0] load_data;
  logic          load_last;
  logic          load_ready;
  logic          load_done;
  logic [IW:0]   prog_len;
  logic          fetch_req;
  logic [IW-1:0] InstAddress;
  logic [DW-1:0] InstOut;
  logic          inst_valid;
  logic          fetch_fault;

  modport master (
    output load_start, load_valid, load_data, load_last, fetch_req, InstAddress,
    input  load_ready, load_done, prog_len, InstOut, inst_valid, fetch_fault
  );

  modport slave (
    input  load_start, load_valid, load_data, load_last, fetch_req, InstAddress,
    output load_ready, load_done, prog_len, InstOut, inst_valid, fetch_fault
  );

endinterface

// File: rtl/inst_load_packer.sv
// rtl/inst_load_packer.sv - packs MSB-first loader beats into words, FILL-padding a short tail
module inst_load_packer
  import inst_mem_pkg::*;
#(
  parameter int            DW   = 32,
  parameter int            LW   = 8,
  parameter logic [DW-1:0] FILL = {DW{DEFAULT_FILL_BIT}}
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          beat_en,
  input  logic [LW-1:0] beat_data,
  input  logic          beat_last,
  output logic          word_strobe,
  output logic [DW-1:0] word
);

  localparam int BPW = beats_per_word(DW, LW);
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int SW  = $clog2(DW) + 1;

  logic [CW-1:0]    count;
  logic [DW-1:0]    shreg;
  logic [DW+LW-1:0] cat;
  logic [DW-1:0]    assembled;
  logic [SW-1:0]    shamt;
  logic [DW-1:0]    low_mask;
  logic             full;

  assign full = (count == CW'(BPW - 1));

  // The incoming beat completes the word combinationally, so the word is written the same cycle
  always_comb begin
    cat         = {shreg, beat_data};
    assembled   = cat[DW-1:0];
    shamt       = SW'((BPW - 1 - int'(count)) * LW);
    low_mask    = ~({DW{1'b1}} << shamt);
    word        = (assembled << shamt) | (FILL & low_mask);
    word_strobe = beat_en && (full || beat_last);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      shreg <= '0;
    end else if (clear) begin
      count <= '0;
      shreg <= '0;
    end else if (beat_en) begin
      shreg <= assembled;
      if (full || beat_last) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/inst_mem_loadable.sv
// rtl/inst_mem_loadable.sv - run-time loadable instruction memory with registered, range-checked fetch
module inst_mem_loadable
  import inst_mem_pkg::*;
#(
  parameter int            IW   = 9,
  parameter int            DW   = 32,
  parameter int            LW   = 8,
  parameter logic [DW-1:0] FILL = {DW{DEFAULT_FILL_BIT}}
) (
  input logic                CLK,
  input logic                reset_n,
  inst_mem_loadable_if.slave bus
);

  state_t        state;
  logic [IW:0]   prog_len;
  logic [IW-1:0] wr_ptr;
  logic          load_ready_q;
  logic          load_done_q;
  logic [DW-1:0] inst_out_q;
  logic          inst_valid_q;
  logic          fetch_fault_q;

  logic          beat;
  logic          word_strobe;
  logic [DW-1:0] word;
  logic          in_range;

  logic [DW-1:0] mem [2**IW];

  // A beat coinciding with load_start belongs to the aborted load and is dropped
  assign beat     = bus.load_valid && load_ready_q && !bus.load_start;
  assign in_range = ({1'b0, bus.InstAddress} < prog_len);

  inst_load_packer #(
    .DW   (DW),
    .LW   (LW),
    .FILL (FILL)
  ) u_packer (
    .clk         (CLK),
    .rst_n       (reset_n),
    .clear       (bus.load_start),
    .beat_en     (beat),
    .beat_data   (bus.load_data),
    .beat_last   (bus.load_last),
    .word_strobe (word_strobe),
    .word        (word)
  );

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      prog_len     <= '0;
      wr_ptr       <= '0;
      load_ready_q <= 1'b0;
      load_done_q  <= 1'b0;
    end else begin
      load_done_q <= 1'b0;
      if (bus.load_start) begin
        state        <= LOAD;
        prog_len     <= '0;
        wr_ptr       <= '0;
        load_ready_q <= 1'b1;
      end else if (state == LOAD && beat) begin
        if (word_strobe) begin
          wr_ptr   <= wr_ptr + 1'b1;
          prog_len <= prog_len + 1'b1;
        end
        // Writing the top address fills the array and ends the load like load_last
        if (bus.load_last || (word_strobe && (&wr_ptr))) begin
          state        <= RUN;
          load_done_q  <= 1'b1;
          load_ready_q <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (beat && word_strobe) begin
      mem[wr_ptr] <= word;
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      inst_out_q    <= FILL;
      inst_valid_q  <= 1'b0;
      fetch_fault_q <= 1'b0;
    end else if (bus.fetch_req && state != LOAD) begin
      inst_valid_q <= 1'b1;
      if (state == RUN && in_range) begin
        inst_out_q    <= mem[bus.InstAddress];
        fetch_fault_q <= 1'b0;
      end else begin
        inst_out_q    <= FILL;
        fetch_fault_q <= 1'b1;
      end
    end else begin
      inst_valid_q <= 1'b0;
    end
  end

  assign bus.load_ready  = load_ready_q;
  assign bus.load_done   = load_done_q;
  assign bus.prog_len    = prog_len;
  assign bus.InstOut     = inst_out_q;
  assign bus.inst_valid  = inst_valid_q;
  assign bus.fetch_fault = fetch_fault_q;

endmodule

// File: doc/inst_mem_loadable.md
Name: inst_mem_loadable

Overview:
Parametrised, run-time-loadable instruction memory for the fetch stage. It replaces a fixed, combinationally read ROM. A byte-serial loader port fills the array with a program. The fetch port then reads it with one-cycle registered latency and flags fetches beyond the loaded program length. It sits between the program loader (testbench or boot path) and the PC/fetch logic.

Parameters:
IW, 9, instruction address width; depth = 2**IW words
DW, 32, instruction word width; must be a multiple of LW
LW, 8, loader beat width
FILL, {DW{1'b1}}, word returned for unloaded or out-of-range addresses (HALT-like trap)

Ports:
CLK  in  1  clock, rising edge
reset_n  in  1  asynchronous, active-low reset
load_start  in  1  pulse: begin a new program load
load_valid  in  1  loader beat valid
load_data  in  LW  loader beat; MSB-first within a word
load_last  in  1  marks the final beat of the program
load_ready  out  1  block accepts a beat this cycle
load_done  out  1  one-cycle pulse when a load completes
prog_len  out  IW+1  number of loaded words
fetch_req  in  1  fetch request
InstAddress  in  IW  fetch address
InstOut  out  DW  fetched instruction
inst_valid  out  1  InstOut valid (one cycle after fetch_req)
fetch_fault  out  1  qualifies InstOut: address >= prog_len, or no program loaded

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low on reset_n.
- Reset values: state=IDLE, prog_len=0, wr_ptr=0, beat count=0, InstOut=FILL, inst_valid=0, fetch_fault=0, load_ready=0, load_done=0. Array contents are not reset.
- States:
  - IDLE: after reset; nothing loaded. load_start -> LOAD.
  - LOAD: load_ready=1; fetches are suppressed.
  - RUN: program valid. load_start -> LOAD (reload).
- LOAD beat handshake: a beat transfers when load_valid && load_ready.
  - Beats shift into a DW-bit packer, MSB-first.
  - After DW/LW beats, the word is written to mem[wr_ptr]; wr_ptr++, prog_len++.
- load_last on a transferred beat:
  - A partial word is completed by padding the remaining low bits with FILL bits, then written.
  - Next cycle: state=RUN, load_done=1 for one cycle, load_ready=0.
- Full array: when wr_ptr wraps past 2**IW-1 (prog_len reaches 2**IW), the load ends as if load_last had been seen. Further beats are not accepted (load_ready=0).
- load_start while in LOAD restarts the load:
  - wr_ptr=0, prog_len=0, packer cleared.
  - A beat in the same cycle as load_start is ignored.
- load_start entering LOAD from RUN (or IDLE) also clears prog_len and wr_ptr.
- Fetch, one-cycle latency:
  - fetch_req sampled at edge N sets inst_valid=1 at edge N+1.
  - RUN and InstAddress < prog_len: InstOut=mem[InstAddress], fetch_fault=0.
  - RUN and InstAddress >= prog_len: InstOut=FILL, fetch_fault=1.
  - IDLE: InstOut=FILL, fetch_fault=1.
  - LOAD: fetch_req ignored, inst_valid=0.
  - No fetch_req: inst_valid=0; InstOut and fetch_fault hold their last values.
- Back-to-back fetch_req every cycle yields one result per cycle.
- Reset asserted mid-load or mid-fetch returns immediately to the reset values. Any partially packed word is discarded.
- prog_len width is IW+1 so a full array (2**IW) is representable.

Decomposition:
- Package inst_mem_pkg:
  - state enum {IDLE, LOAD, RUN}
  - BEATS_PER_WORD = DW/LW as a localparam function
  - default FILL constant
- Natural sub-module: inst_load_packer. It holds the beat counter, the shift register and FILL padding, and outputs a word-complete strobe plus the word.

Test Plan:
- Reset, then fetch_req with InstAddress=0 -> next cycle inst_valid=1, InstOut=32'hFFFFFFFF, fetch_fault=1.
- load_start; 8 beats 0x74,0x01,0x00,0x40, 0x74,0x04,0x00,0x80 (last on 8th) -> load_done pulse, prog_len=2. Fetch addr 0 -> 32'h74010040, fault=0. Fetch addr 1 -> 32'h74040080. Fetch addr 2 -> FILL, fault=1.
- load_valid deasserted for 3 cycles between beats 2 and 3 -> identical words stored; load_ready stays 1.
- 6 beats ending with load_last on beat 6 -> word 1 = {beat5, beat6, 16'hFFFF}; prog_len=2.
- Reload from RUN:
  - load_start then 4 beats 0x00,0x00,0x00,0x01 -> prog_len=1, addr 0 = 32'h00000001, addr 1 faults.
  - fetch_req during LOAD -> inst_valid=0.
- IW=2 build: 16 beats without load_last -> auto-complete, prog_len=4, load_ready drops. A 17th beat is not accepted.
- Assert reset_n=0 after 3 beats of a load -> IDLE, prog_len=0, load_ready=0 asynchronously.
